// File: rtl/cdc_command_sequencer.sv
// Host-side command/status sequencer: collects a CDB byte-by-byte under a REQ/ACK
// handshake, hands off to an executor, then returns status and message bytes.
module cdc_command_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_i,
  input  logic       ack_i,
  input  logic [7:0] host_data_i,
  input  logic       exec_done_i,
  input  logic [7:0] status_code_i,
  output logic [7:0] cdc_stat_o,
  output logic [7:0] phase_o,
  output logic [7:0] bus_data_o,
  output logic [7:0] cdb_byte_o,
  output logic [3:0] cdb_index_o,
  output logic       cdb_we_o,
  output logic       cdb_valid_o,
  output logic [3:0] cdb_len_o
);

  localparam logic [7:0] STAT_IDLE    = 8'h00;
  localparam logic [7:0] STAT_CMD_REQ = 8'hD0;
  localparam logic [7:0] STAT_CMD_GAP = 8'h90;
  localparam logic [7:0] STAT_EXEC    = 8'h80;
  localparam logic [7:0] STAT_STS_REQ = 8'hD8;
  localparam logic [7:0] STAT_MSG_REQ = 8'hF8;
  localparam logic [7:0] STAT_MSG_GAP = 8'hB8;

  localparam logic [7:0] PH_BUS_FREE = 8'h00;
  localparam logic [7:0] PH_COMMAND  = 8'h01;
  localparam logic [7:0] PH_STATUS   = 8'h08;
  localparam logic [7:0] PH_MSG_IN   = 8'h10;

  typedef enum logic [2:0] {
    S_BUS_FREE,
    S_COMMAND,
    S_EXEC,
    S_STATUS,
    S_MSG_IN
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       req;
  logic       honoured;
  logic [3:0] len_eff;
  logic       last_byte;

  // CDB group code in opcode[7:5] fixes the command length.
  function automatic logic [3:0] len_from_opcode(input logic [7:0] op);
    case (op[7:5])
      3'd0, 3'd3, 3'd4: len_from_opcode = 4'd6;
      3'd5:             len_from_opcode = 4'd12;
      default:          len_from_opcode = 4'd10;
    endcase
  endfunction

  assign req      = cdc_stat_o[6];
  assign honoured = req && ack_i;

  // The opcode byte decides the length in the same cycle it arrives.
  always_comb begin
    len_eff   = (cnt == 4'd0) ? len_from_opcode(host_data_i) : cdb_len_o;
    last_byte = ((cnt + 4'd1) == len_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BUS_FREE;
      cnt         <= 4'd0;
      cdc_stat_o  <= STAT_IDLE;
      phase_o     <= PH_BUS_FREE;
      bus_data_o  <= 8'h00;
      cdb_byte_o  <= 8'h00;
      cdb_index_o <= 4'd0;
      cdb_we_o    <= 1'b0;
      cdb_valid_o <= 1'b0;
      cdb_len_o   <= 4'd0;
    end else begin
      cdb_we_o    <= 1'b0;
      cdb_valid_o <= 1'b0;
      case (state)
        S_BUS_FREE: begin
          if (sel_i) begin
            state      <= S_COMMAND;
            cnt        <= 4'd0;
            cdc_stat_o <= STAT_CMD_REQ;
            phase_o    <= PH_COMMAND;
          end
        end
        S_COMMAND: begin
          if (honoured) begin
            cdb_we_o    <= 1'b1;
            cdb_byte_o  <= host_data_i;
            cdb_index_o <= cnt;
            if (cnt == 4'd0) cdb_len_o <= len_eff;
            // Counter parks at 0 on the last byte so it never passes 11.
            if (last_byte) begin
              cdb_valid_o <= 1'b1;
              state       <= S_EXEC;
              cdc_stat_o  <= STAT_EXEC;
              cnt         <= 4'd0;
            end else begin
              cnt        <= cnt + 4'd1;
              cdc_stat_o <= STAT_CMD_GAP;
            end
          end else if (!req) begin
            cdc_stat_o <= STAT_CMD_REQ;
          end
        end
        S_EXEC: begin
          if (exec_done_i) begin
            bus_data_o <= status_code_i;
            state      <= S_STATUS;
            cdc_stat_o <= STAT_STS_REQ;
            phase_o    <= PH_STATUS;
          end
        end
        S_STATUS: begin
          if (honoured) begin
            bus_data_o <= 8'h00;
            state      <= S_MSG_IN;
            cdc_stat_o <= STAT_MSG_GAP;
            phase_o    <= PH_MSG_IN;
          end else if (!req) begin
            cdc_stat_o <= STAT_STS_REQ;
          end
        end
        S_MSG_IN: begin
          if (honoured) begin
            state      <= S_BUS_FREE;
            cdc_stat_o <= STAT_IDLE;
            phase_o    <= PH_BUS_FREE;
            cdb_len_o  <= 4'd0;
          end else if (!req) begin
            cdc_stat_o <= STAT_MSG_REQ;
          end
        end
        default: begin
          state      <= S_BUS_FREE;
          cdc_stat_o <= STAT_IDLE;
          phase_o    <= PH_BUS_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_command_sequencer.sv
// Randomized bench for cdc_command_sequencer against a transaction-level model of
// the command / exec / status / message sequence.
module tb_cdc_command_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel_i = 1'b0;
  logic       ack_i = 1'b0;
  logic [7:0] host_data_i = 8'h00;
  logic       exec_done_i = 1'b0;
  logic [7:0] status_code_i = 8'h00;
  logic [7:0] cdc_stat_o, phase_o, bus_data_o, cdb_byte_o;
  logic [3:0] cdb_index_o, cdb_len_o;
  logic       cdb_we_o, cdb_valid_o;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int valid_cnt = 0;

  // CDB length per opcode group (opcode[7:5]).
  int len_tab [8] = '{6, 10, 10, 6, 6, 12, 10, 10};

  cdc_command_sequencer dut (
    .clk(clk), .reset(reset), .sel_i(sel_i), .ack_i(ack_i),
    .host_data_i(host_data_i), .exec_done_i(exec_done_i),
    .status_code_i(status_code_i), .cdc_stat_o(cdc_stat_o),
    .phase_o(phase_o), .bus_data_o(bus_data_o), .cdb_byte_o(cdb_byte_o),
    .cdb_index_o(cdb_index_o), .cdb_we_o(cdb_we_o),
    .cdb_valid_o(cdb_valid_o), .cdb_len_o(cdb_len_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (cdb_we_o === 1'b1) we_cnt++;
    if (cdb_valid_o === 1'b1) valid_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- drivers (no checking) ----
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cdc_stat_o[6] === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ack(input logic [7:0] d);
    ack_i = 1'b1; host_data_i = d;
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  task automatic do_select();
    sel_i = 1'b1;
    @(negedge clk);
    sel_i = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] op, input int n, output bit ok);
    bit r;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_req(r);
      if (!r) ok = 1'b0;
      pulse_ack((i == 0) ? op : 8'($urandom));
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cdc_stat_o !== 8'h00) begin bad++; $display("FAIL reset_stat: got %0h want 00", cdc_stat_o); end
    total++; if (phase_o !== 8'h00) begin bad++; $display("FAIL reset_phase: got %0h want 00", phase_o); end
    total++; if ({bus_data_o, cdb_byte_o, cdb_index_o, cdb_len_o, cdb_we_o, cdb_valid_o} !== 26'd0) begin
      bad++; $display("FAIL reset_outs: got %0h want 0", {bus_data_o, cdb_byte_o, cdb_index_o, cdb_len_o, cdb_we_o, cdb_valid_o});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_status();
    logic [7:0] code;
    int w0;
    bit ok;
    w0 = we_cnt;
    // Stray acks and selects while executing must be ignored.
    for (int k = 0; k < 4; k++) begin
      ack_i = 1'($urandom); sel_i = 1'($urandom); host_data_i = 8'($urandom);
      @(negedge clk);
    end
    ack_i = 1'b0; sel_i = 1'b0;
    @(negedge clk);
    total++; if (cdc_stat_o !== 8'h80 || phase_o !== 8'h01) begin bad++; $display("FAIL exec_hold: got stat %0h phase %0h want 80 01", cdc_stat_o, phase_o); end
    total++; if (we_cnt !== w0) begin bad++; $display("FAIL exec_ack_ignored: got %0d writes want %0d", we_cnt, w0); end
    code = 8'($urandom);
    exec_done_i = 1'b1; status_code_i = code;
    @(negedge clk);
    exec_done_i = 1'b0; status_code_i = 8'h5A;
    total++; if (cdc_stat_o !== 8'hD8 || bus_data_o !== code || phase_o !== 8'h08) begin
      bad++; $display("FAIL status_enter: got %0h/%0h/%0h want D8/%0h/08", cdc_stat_o, bus_data_o, phase_o, code);
    end
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL status_req_timeout: got 0 want 1"); end
    pulse_ack(8'h00);
    total++; if (cdc_stat_o !== 8'hB8 || bus_data_o !== 8'h00 || phase_o !== 8'h10) begin
      bad++; $display("FAIL msg_gap: got %0h/%0h/%0h want B8/00/10", cdc_stat_o, bus_data_o, phase_o);
    end
    @(negedge clk);
    total++; if (cdc_stat_o !== 8'hF8) begin bad++; $display("FAIL msg_req: got %0h want F8", cdc_stat_o); end
    pulse_ack(8'h00);
    total++; if (cdc_stat_o !== 8'h00 || phase_o !== 8'h00 || cdb_len_o !== 4'd0) begin
      bad++; $display("FAIL bus_free: got %0h/%0h/%0h want 00/00/0", cdc_stat_o, phase_o, cdb_len_o);
    end
  endtask

  task automatic test_command(input int ncmd);
    logic [7:0] op, d;
    int len, w0, v0;
    bit ok, last;
    for (int n = 0; n < ncmd; n++) begin
      op = (n == 0) ? 8'h08 : (n == 1) ? 8'hD8 : (n == 2) ? (8'hA0 | 8'($urandom_range(0, 31))) : 8'($urandom);
      len = len_tab[op[7:5]];
      do_select();
      total++; if (phase_o !== 8'h01 || cdc_stat_o !== 8'hD0) begin
        bad++; $display("FAIL select: got phase %0h stat %0h want 01 D0", phase_o, cdc_stat_o);
      end
      w0 = we_cnt; v0 = valid_cnt;
      for (int i = 0; i < len; i++) begin
        d = (i == 0) ? op : 8'($urandom);
        last = (i == len - 1);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL cmd_req_timeout: got 0 want 1 at byte %0d", i); end
        pulse_ack(d);
        total++; if (cdb_we_o !== 1'b1 || cdb_index_o !== 4'(i) || cdb_byte_o !== d) begin
          bad++; $display("FAIL cdb_write: got we %0b idx %0d byte %0h want 1 %0d %0h", cdb_we_o, cdb_index_o, cdb_byte_o, i, d);
        end
        total++; if (cdb_len_o !== 4'(len)) begin bad++; $display("FAIL cdb_len: got %0d want %0d", cdb_len_o, len); end
        total++; if (cdb_valid_o !== last || cdc_stat_o !== (last ? 8'h80 : 8'h90)) begin
          bad++; $display("FAIL byte_stat: got valid %0b stat %0h want %0b %0h", cdb_valid_o, cdc_stat_o, last, last ? 8'h80 : 8'h90);
        end
        if (!last) begin
          // Optional ack during the REQ gap; REQ must come back after one cycle regardless.
          ack_i = 1'($urandom); host_data_i = 8'($urandom);
          @(negedge clk);
          ack_i = 1'b0;
          total++; if (cdb_we_o !== 1'b0 || cdc_stat_o !== 8'hD0) begin
            bad++; $display("FAIL req_gap: got we %0b stat %0h want 0 D0", cdb_we_o, cdc_stat_o);
          end
        end
      end
      total++; if (we_cnt - w0 !== len || valid_cnt - v0 !== 1) begin
        bad++; $display("FAIL cmd_counts: got %0d writes %0d valids want %0d 1", we_cnt - w0, valid_cnt - v0, len);
      end
      test_status();
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_select();
    send_bytes(8'h28, 3, ok);
    total++; if (!ok || cdb_index_o !== 4'd2) begin bad++; $display("FAIL mid_setup: got ok %0b idx %0d want 1 2", ok, cdb_index_o); end
    reset = 1'b1; sel_i = 1'b1; ack_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; sel_i = 1'b0; ack_i = 1'b0;
    total++; if ({cdc_stat_o, phase_o, bus_data_o, cdb_byte_o, cdb_index_o, cdb_len_o, cdb_we_o, cdb_valid_o} !== 42'd0) begin
      bad++; $display("FAIL mid_reset: got %0h want 0", {cdc_stat_o, phase_o, bus_data_o, cdb_byte_o, cdb_index_o, cdb_len_o, cdb_we_o, cdb_valid_o});
    end
    do_select();
    send_bytes(8'h12, 1, ok);
    total++; if (!ok || cdb_we_o !== 1'b1 || cdb_index_o !== 4'd0 || cdb_byte_o !== 8'h12) begin
      bad++; $display("FAIL restart: got we %0b idx %0d byte %0h want 1 0 12", cdb_we_o, cdb_index_o, cdb_byte_o);
    end
    // Abort mid-STATUS as well.
    send_bytes(8'h00, 9, ok);
    exec_done_i = 1'b1; status_code_i = 8'h02;
    @(negedge clk);
    exec_done_i = 1'b0;
    reset = 1'b1; ack_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; ack_i = 1'b0;
    total++; if (cdc_stat_o !== 8'h00 || phase_o !== 8'h00 || bus_data_o !== 8'h00) begin
      bad++; $display("FAIL status_reset: got %0h/%0h/%0h want 00/00/00", cdc_stat_o, phase_o, bus_data_o);
    end
  endtask

  task automatic test_ignored();
    int w0;
    bit ok;
    w0 = we_cnt;
    exec_done_i = 1'b1; status_code_i = 8'hEE; ack_i = 1'b1;
    @(negedge clk);
    exec_done_i = 1'b0; ack_i = 1'b0;
    @(negedge clk);
    total++; if (cdc_stat_o !== 8'h00 || phase_o !== 8'h00 || bus_data_o !== 8'h00 || we_cnt !== w0) begin
      bad++; $display("FAIL idle_ignore: got %0h/%0h/%0h writes %0d want 00/00/00 %0d", cdc_stat_o, phase_o, bus_data_o, we_cnt, w0);
    end
    sel_i = 1'b1; ack_i = 1'b1; host_data_i = 8'h77;
    @(negedge clk);
    sel_i = 1'b0; ack_i = 1'b0;
    total++; if (cdc_stat_o !== 8'hD0 || cdb_we_o !== 1'b0 || we_cnt !== w0) begin
      bad++; $display("FAIL sel_beats_ack: got stat %0h writes %0d want D0 %0d", cdc_stat_o, we_cnt, w0);
    end
    send_bytes(8'h08, 6, ok);
    exec_done_i = 1'b1; status_code_i = 8'h02;
    @(negedge clk);
    exec_done_i = 1'b0;
    sel_i = 1'b1;
    repeat (2) @(negedge clk);
    sel_i = 1'b0;
    total++; if (!ok || cdc_stat_o !== 8'hD8 || phase_o !== 8'h08 || bus_data_o !== 8'h02) begin
      bad++; $display("FAIL status_sel_ignored: got %0h/%0h/%0h want D8/08/02", cdc_stat_o, phase_o, bus_data_o);
    end
    pulse_ack(8'h00);
    @(negedge clk);
    pulse_ack(8'h00);
    total++; if (cdc_stat_o !== 8'h00 || phase_o !== 8'h00) begin
      bad++; $display("FAIL ignore_exit: got %0h/%0h want 00/00", cdc_stat_o, phase_o);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_command(8);
    test_mid_reset();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_command_sequencer.md
CDC_COMMAND_SEQUENCER -- requirements
Module: cdc_command_sequencer

Interface
REQ-001 Port `clk`, input, 1: single clock for the whole block; all state updates on its rising edge.
REQ-002 Port `reset`, input, 1: synchronous, active-high reset.
REQ-003 Port `sel_i`, input, 1: host select request; level-sampled.
REQ-004 Port `ack_i`, input, 1: host acknowledge; one-cycle pulse per byte transfer.
REQ-005 Port `host_data_i`, input, 8: command byte from host; valid when `ack_i`=1.
REQ-006 Port `exec_done_i`, input, 1: downstream executor finished; one-cycle pulse.
REQ-007 Port `status_code_i`, input, 8: SCSI status byte; valid with `exec_done_i`.
REQ-008 Port `cdc_stat_o`, output, 8: {BSY,REQ,MSG,CD,IO,3'b000}, i.e. BSY=0x80, REQ=0x40, MSG=0x20, CD=0x10, IO=0x08.
REQ-009 Port `phase_o`, output, 8: BUS_FREE=0x00, COMMAND=0x01, DATA_IN=0x02, STATUS=0x08, MESSAGE_IN=0x10.
REQ-010 Port `bus_data_o`, output, 8: byte presented to host in STATUS/MESSAGE_IN.
REQ-011 Port `cdb_byte_o`, output, 8, and `cdb_index_o`, output, 4: captured command byte and its position 0..11.
REQ-012 Port `cdb_we_o`, output, 1: one-cycle strobe qualifying `cdb_byte_o`/`cdb_index_o`.
REQ-013 Port `cdb_valid_o`, output, 1: one-cycle pulse when the full CDB has been received.
REQ-014 Port `cdb_len_o`, output, 4: expected CDB length; held from opcode capture until the next BUS_FREE.

Function
REQ-015 FSM states SHALL be: BUS_FREE, COMMAND, EXEC, STATUS, MSG_IN.
REQ-016 `cdc_stat_o` SHALL be registered and SHALL equal, per state: BUS_FREE 0x00; COMMAND 0xD0 while awaiting a byte; EXEC 0x80; STATUS 0xD8; MSG_IN 0xF8.
REQ-017 `phase_o` SHALL read COMMAND in COMMAND and in EXEC; all other states map per REQ-009. DATA_IN is reserved and never driven.
REQ-018 BUS_FREE -> COMMAND SHALL occur on the first cycle `sel_i`=1; the byte counter SHALL clear to 0 and REQ SHALL be set the following cycle.
REQ-019 `ack_i` SHALL be honoured only when REQ=1. An honoured ack SHALL produce `cdb_we_o`=1, `cdb_byte_o`=`host_data_i` and `cdb_index_o`=counter in the next cycle; the counter SHALL then increment.
REQ-020 After each honoured ack, REQ SHALL be low for exactly one cycle before it re-asserts, unless the phase changes.
REQ-021 On byte index 0, `cdb_len_o` SHALL be set from opcode[7:5]: 0 -> 6; 1, 2, 6, 7 -> 10; 5 -> 12; 3, 4 -> 6.
REQ-022 When counter+1 equals `cdb_len_o`, the sequencer SHALL pulse `cdb_valid_o` in the same cycle as the last `cdb_we_o` and enter EXEC, with REQ=0.
REQ-023 In EXEC, `exec_done_i`=1 SHALL latch `status_code_i` into `bus_data_o` and enter STATUS with REQ=1 the next cycle.
REQ-024 An honoured ack in STATUS SHALL set `bus_data_o`=0x00 and enter MSG_IN, with REQ asserted per REQ-020.
REQ-025 An honoured ack in MSG_IN SHALL enter BUS_FREE; `cdc_stat_o`=0x00 the next cycle.
REQ-026 `sel_i` SHALL be ignored outside BUS_FREE; `exec_done_i` SHALL be ignored outside EXEC.
REQ-027 `ack_i` SHALL be ignored when REQ=0, including the one-cycle gap and all of EXEC and BUS_FREE.
REQ-028 The counter is 4 bits and SHALL never exceed 11; there is no wrap-around path.
REQ-029 If `sel_i` and an `ack_i` arrive together in BUS_FREE, selection SHALL win and the ack SHALL be discarded.

Reset
REQ-030 `reset`=1 SHALL, on the next edge, force BUS_FREE from any state and clear all outputs: `cdc_stat_o`=0x00, `phase_o`=0x00, `bus_data_o`=0x00, `cdb_*`=0, counter=0.
REQ-031 Reset SHALL take priority over every other input in the same cycle, including reset asserted mid-CDB or mid-STATUS.

Verification
REQ-032 Reset, then `sel_i`=1 -> `phase_o`=0x01, `cdc_stat_o`=0xD0.
REQ-033 Send 6 bytes of opcode 0x08 (READ6), one ack per REQ -> `cdb_we_o` indices 0..5, `cdb_len_o`=6, `cdb_valid_o` pulses once, `cdc_stat_o`=0x80.
REQ-034 Send opcode 0xD8 -> `cdb_len_o`=10; `cdb_valid_o` only after the 10th byte; an `ack_i` during the REQ gap is ignored (no extra `cdb_we_o`).
REQ-035 From EXEC, `exec_done_i` with `status_code_i`=0x02, then an ack -> `cdc_stat_o`=0xD8 and `bus_data_o`=0x02; next, `cdc_stat_o`=0xF8 and `bus_data_o`=0x00; a final ack -> `cdc_stat_o`=0x00, `phase_o`=0x00.
REQ-036 Assert `reset` after the 3rd command byte -> next cycle all outputs 0; a subsequent `sel_i` restarts at index 0.
REQ-037 Pulse `exec_done_i` in BUS_FREE and assert `sel_i` during STATUS -> no state change.
